mem_arbiter: RTL and testbench

//   Two-requester arbiter/sequencer for the shared 1024x32 async-read, sync-write memory.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_rr_arbiter2.sv | 43 ++++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: widths, FSM state encodings and port ids.
package mem_arbiter_pkg;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned MEM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input grant logic with a last-grant pointer.
// MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties); default is round-robin.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       gnt_valid_c_o,
  output logic       gnt_id_c_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_valid_c_o = |req_i;
`ifdef MEM_ARB_FIXED_PRIO_EN
    gnt_id_c_o    = req_i[0] ? PORT0 : PORT1;
`else
    // On a tie the port not granted last time wins.
    if (&req_i) begin
      gnt_id_c_o = ~last_q;
    end else begin
      gnt_id_c_o = req_i[0] ? PORT0 : PORT1;
    end
`endif
    last_d = last_q;
    if (adv_i && gnt_valid_c_o) begin
      last_d = gnt_id_c_o;
    end
  end

  // Pointer resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a shared async-read, sync-write memory.
// Build option: MEM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin, see rr_arbiter2).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW = MEM_AW,
  parameter int unsigned DW = MEM_DW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          We0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] WData0,
  output logic          Ack0,
  output logic [DW-1:0] RData0,
  input  logic          Req1,
  input  logic          We1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData1,
  output logic          Ack1,
  output logic [DW-1:0] RData1,
  output logic          CS_,
  output logic          RD_,
  output logic          WR_,
  output logic [AW-1:0] Addr,
  inout  tri   [DW-1:0] Data
);

  state_e        state_q, state_d;
  logic          id_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          ack0_q, ack1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          load_c, gnt_valid_c, gnt_id_c, in_access_c, data_oe_c;

  rr_arbiter2 u_arb (
    .clk_i         (Clk),
    .reset_i       (Reset),
    .req_i         ({Req1, Req0}),
    .adv_i         (load_c),
    .gnt_valid_c_o (gnt_valid_c),
    .gnt_id_c_o    (gnt_id_c)
  );

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          load_c  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      id_q     <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        id_q    <= gnt_id_c;
        we_q    <= gnt_id_c ? We1 : We0;
        addr_q  <= gnt_id_c ? Addr1 : Addr0;
        wdata_q <= gnt_id_c ? WData1 : WData0;
      end
      // Ack lands in RESP; read data is captured off the bus at the end of ACCESS.
      ack0_q <= (state_q == ST_ACCESS) && (id_q == PORT0);
      ack1_q <= (state_q == ST_ACCESS) && (id_q == PORT1);
      if ((state_q == ST_ACCESS) && !we_q) begin
        if (id_q == PORT0) begin
          rdata0_q <= Data;
        end else begin
          rdata1_q <= Data;
        end
      end
    end
  end

  // Strobes are gated with Reset so an access coinciding with reset never reaches memory.
  always_comb begin
    in_access_c = (state_q == ST_ACCESS) && !Reset;
    data_oe_c   = in_access_c && we_q;
    CS_         = ~in_access_c;
    RD_         = ~(in_access_c && !we_q);
    WR_         = ~(in_access_c && we_q);
  end

  assign Data   = data_oe_c ? wdata_q : {DW{1'bz}};
  assign Addr   = addr_q;
  assign Ack0   = ack0_q;
  assign Ack1   = ack1_q;
  assign RData0 = rdata0_q;
  assign RData1 = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural async-read/sync-write memory on the bus.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Req0, We0, Req1, We1;
  logic [9:0]  Addr0, Addr1;
  logic [31:0] WData0, WData1;
  wire         Ack0, Ack1, CS_, RD_, WR_;
  wire  [31:0] RData0, RData1;
  wire  [9:0]  Addr;
  tri   [31:0] Data;

  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  mem_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0), .Ack0(Ack0), .RData0(RData0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1), .Ack1(Ack1), .RData1(RData1),
    .CS_(CS_), .RD_(RD_), .WR_(WR_), .Addr(Addr), .Data(Data)
  );

  always #5 Clk = ~Clk;

  // Memory model: drives the bus only for a read, captures writes on posedge.
  assign Data = (CS_ === 1'b0 && RD_ === 1'b0) ? mem[Addr] : {32{1'bz}};
  always @(posedge Clk) if (CS_ === 1'b0 && WR_ === 1'b0) mem[Addr] <= Data;

  // Per-cycle bus protocol checker.
  always @(negedge Clk) begin
    if (mon_en) begin
      checks++;
      if (RD_ === 1'b0 && WR_ === 1'b0) begin
        errors++; $display("FAIL strobe_overlap RD_=%b WR_=%b required not both 0", RD_, WR_);
      end
      checks++;
      if (RD_ === 1'b0 && dut.data_oe_c !== 1'b0) begin
        errors++; $display("FAIL drive_during_read data_oe=%b required 0", dut.data_oe_c);
      end
      checks++;
      if (Ack0 === 1'b1 && Ack1 === 1'b1) begin
        errors++; $display("FAIL ack_overlap Ack0=%b Ack1=%b required not both 1", Ack0, Ack1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  // Drives one request and waits (bounded) for its Ack; records what the bus did.
  task automatic run_txn(input logic port, input logic we, input logic [9:0] a,
                         input logic [31:0] wd, output int lat, output int rd_n,
                         output int wr_n, output logic [9:0] a_seen,
                         output bit other_ack, output logic oe_resp);
    @(negedge Clk);
    if (port == PORT0) begin
      Req0 = 1'b1; We0 = we; Addr0 = a; WData0 = wd;
    end else begin
      Req1 = 1'b1; We1 = we; Addr1 = a; WData1 = wd;
    end
    lat = -1; rd_n = 0; wr_n = 0; a_seen = '0; other_ack = 1'b0; oe_resp = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (RD_ === 1'b0) rd_n++;
      if (WR_ === 1'b0) wr_n++;
      if (CS_ === 1'b0) a_seen = Addr;
      if (((port == PORT0) ? Ack1 : Ack0) === 1'b1) other_ack = 1'b1;
      if (((port == PORT0) ? Ack0 : Ack1) === 1'b1) begin
        lat = k; oe_resp = dut.data_oe_c; break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout port=%0d no Ack within 10 cycles", port);
    end
    Req0 = 1'b0; Req1 = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (CS_ !== 1'b1) begin errors++; $display("FAIL rst_cs CS_=%b required 1", CS_); end
    checks++; if (RD_ !== 1'b1) begin errors++; $display("FAIL rst_rd RD_=%b required 1", RD_); end
    checks++; if (WR_ !== 1'b1) begin errors++; $display("FAIL rst_wr WR_=%b required 1", WR_); end
    checks++; if (Addr !== 10'h000) begin errors++; $display("FAIL rst_addr Addr=%h required 000", Addr); end
    checks++; if (Ack0 !== 1'b0 || Ack1 !== 1'b0) begin errors++; $display("FAIL rst_ack Ack0=%b Ack1=%b required 0 0", Ack0, Ack1); end
    checks++; if (RData0 !== 32'h0 || RData1 !== 32'h0) begin errors++; $display("FAIL rst_rdata RData0=%h RData1=%h required 0 0", RData0, RData1); end
    checks++; if (dut.data_oe_c !== 1'b0) begin errors++; $display("FAIL rst_data_oe oe=%b required 0", dut.data_oe_c); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rst_state state=%0d required %0d", dut.state_q, ST_IDLE); end
    Reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_write();
    int lat, rd_n, wr_n; logic [9:0] as; bit oa; logic oe;
    run_txn(PORT0, 1'b1, 10'h005, 32'hDEADBEEF, lat, rd_n, wr_n, as, oa, oe);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency got=%0d required 2", lat); end
    checks++; if (wr_n != 1 || rd_n != 0) begin errors++; $display("FAIL wr_strobes WR_low=%0d RD_low=%0d required 1 0", wr_n, rd_n); end
    checks++; if (as !== 10'h005) begin errors++; $display("FAIL wr_addr got=%h required 005", as); end
    checks++; if (oa) begin errors++; $display("FAIL wr_other_ack got=1 required 0"); end
    checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem mem[5]=%h required deadbeef", mem[5]); end
  endtask

  task automatic test_read();
    int lat, rd_n, wr_n; logic [9:0] as; bit oa; logic oe;
    run_txn(PORT0, 1'b0, 10'h005, 32'h0, lat, rd_n, wr_n, as, oa, oe);
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency got=%0d required 2", lat); end
    checks++; if (rd_n != 1 || wr_n != 0) begin errors++; $display("FAIL rd_strobes RD_low=%0d WR_low=%0d required 1 0", rd_n, wr_n); end
    checks++; if (RData0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data RData0=%h required deadbeef", RData0); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rd_resp_oe oe=%b required 0", oe); end
    @(negedge Clk);
    checks++; if (RData0 !== 32'hDEADBEEF || Ack0 !== 1'b0) begin errors++; $display("FAIL rd_hold RData0=%h Ack0=%b required deadbeef 0", RData0, Ack0); end
  endtask

  task automatic test_round_robin();
    int lat, rd_n, wr_n; logic [9:0] as; bit oa; logic oe;
    logic e0, e1;
    run_txn(PORT0, 1'b1, 10'h001, 32'hA1A10001, lat, rd_n, wr_n, as, oa, oe);
    run_txn(PORT1, 1'b1, 10'h002, 32'hB2B20002, lat, rd_n, wr_n, as, oa, oe);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 10'h001;
    Req1 = 1'b1; We1 = 1'b0; Addr1 = 10'h002;
    for (int k = 1; k <= 11; k++) begin
      @(negedge Clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
      e0 = (k % 3 == 2);
      e1 = 1'b0;
`else
      e0 = (k == 2) || (k == 8);
      e1 = (k == 5) || (k == 11);
`endif
      checks++;
      if (Ack0 !== e0 || Ack1 !== e1) begin
        errors++; $display("FAIL rr_ack cycle=%0d Ack0=%b Ack1=%b required %b %b", k, Ack0, Ack1, e0, e1);
      end
      if (e0) begin
        checks++; if (RData0 !== 32'hA1A10001) begin errors++; $display("FAIL rr_rdata0 cycle=%0d got=%h required a1a10001", k, RData0); end
      end
      if (e1) begin
        checks++; if (RData1 !== 32'hB2B20002) begin errors++; $display("FAIL rr_rdata1 cycle=%0d got=%h required b2b20002", k, RData1); end
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_top_addr();
    int lat, rd_n, wr_n; logic [9:0] as; bit oa; logic oe;
    run_txn(PORT1, 1'b1, 10'h3FF, 32'h12345678, lat, rd_n, wr_n, as, oa, oe);
    checks++; if (lat != 2) begin errors++; $display("FAIL top_wr_latency got=%0d required 2", lat); end
    checks++; if (as !== 10'h3FF) begin errors++; $display("FAIL top_wr_addr got=%h required 3ff", as); end
    checks++; if (mem[1023] !== 32'h12345678) begin errors++; $display("FAIL top_mem mem[1023]=%h required 12345678", mem[1023]); end
    run_txn(PORT1, 1'b0, 10'h3FF, 32'h0, lat, rd_n, wr_n, as, oa, oe);
    checks++; if (lat != 2 || oa) begin errors++; $display("FAIL top_rd_ack latency=%0d other=%0d required 2 0", lat, oa); end
    checks++; if (RData1 !== 32'h12345678) begin errors++; $display("FAIL top_rd_data RData1=%h required 12345678", RData1); end
  endtask

  task automatic test_reset_abort();
    int lat, rd_n, wr_n; logic [9:0] as; bit oa; logic oe;
    bit saw_ack;
    run_txn(PORT0, 1'b1, 10'h007, 32'h0, lat, rd_n, wr_n, as, oa, oe);
    checks++; if (mem[7] !== 32'h0) begin errors++; $display("FAIL abort_preload mem[7]=%h required 0", mem[7]); end
    @(negedge Clk);
    Req0 = 1'b1; We0 = 1'b1; Addr0 = 10'h007; WData0 = 32'hCAFEF00D;
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    checks++; if (WR_ !== 1'b1 || CS_ !== 1'b1) begin errors++; $display("FAIL abort_strobes WR_=%b CS_=%b required 1 1", WR_, CS_); end
    @(negedge Clk);
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL abort_state state=%0d required %0d", dut.state_q, ST_IDLE); end
    Req0 = 1'b0; Reset = 1'b0;
    saw_ack = (Ack0 === 1'b1);
    repeat (3) begin
      @(negedge Clk);
      if (Ack0 === 1'b1) saw_ack = 1'b1;
    end
    checks++; if (saw_ack) begin errors++; $display("FAIL abort_ack Ack0 seen=1 required 0"); end
    checks++; if (mem[7] !== 32'h0) begin errors++; $display("FAIL abort_mem mem[7]=%h required 0", mem[7]); end
  endtask

  initial begin
    Clk = 1'b0; Reset = 1'b1;
    Req0 = 1'b0; We0 = 1'b0; Addr0 = '0; WData0 = '0;
    Req1 = 1'b0; We1 = 1'b0; Addr1 = '0; WData1 = '0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_top_addr();
    test_reset_abort();
    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
